// File: rtl/mul_pkg.sv
// Shared definitions for the multiply-accumulate slice.
//   state_t : two-state control encoding (accumulating / holding a result)
//   MUL_W   : width of one product from the upstream 8x8 multiplier
//   clog2   : ceiling log2, used to size the beat counter
package mul_pkg;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    localparam int MUL_W = 16;

    // Ceiling log2, never below 1 so a counter always has at least one bit.
    function automatic int clog2(input int value);
        int bits;
        int rem;
        bits = 0;
        rem  = value - 1;
        while (rem > 0) begin
            bits++;
            rem = rem >> 1;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/beat_counter.sv
// Modulo-LEN beat counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_inc      : advance by one (wraps to 0 after LEN-1)
//   i_clr      : synchronous clear, takes priority over i_inc
//   o_tc       : terminal count, high while the count equals LEN-1
module beat_counter
    import mul_pkg::*;
#(
    parameter int LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_tc
);

    localparam int CNT_W = clog2(LEN);

    logic [CNT_W-1:0] r_count;
    logic             w_tc;

    assign w_tc = (r_count == CNT_W'(LEN - 1));
    assign o_tc = w_tc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= w_tc ? '0 : r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mul_accumulator.sv
// Dot-product accumulator behind the 8x8 unsigned multiplier.
// Sums LEN consecutive 16-bit products into an ACC_W-bit result and presents
// it on a valid/ready port; input is stalled while a result is held.
//   clk, rst_n          : clock, asynchronous active-low reset
//   clear               : abort the partial group (ignored while holding a result)
//   mul, in_valid       : product beat in / in_ready : beat accepted this cycle
//   acc_out, out_valid  : completed sum / out_ready : consumer takes it
//   ovf                 : the delivered sum wrapped past 2^ACC_W-1
module mul_accumulator
    import mul_pkg::*;
#(
    parameter int LEN   = 8,
    parameter int ACC_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [MUL_W-1:0] mul,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             ovf
);

    state_t           r_state;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_acc_out;
    logic             r_sticky;
    logic             r_ovf;

    logic             w_accum;
    logic             w_fire;
    logic             w_clr;
    logic             w_last;
    logic [ACC_W:0]   w_sum;

    assign w_accum = (r_state == ST_ACCUM);
    // clear wins over a beat in the same cycle; in HOLD neither has any effect.
    assign w_clr   = w_accum & clear;
    assign w_fire  = w_accum & in_valid & ~clear;

    // One extra bit captures the carry-out of this add for the sticky flag.
    assign w_sum = {1'b0, r_acc} + {{(ACC_W + 1 - MUL_W){1'b0}}, mul};

    beat_counter #(
        .LEN   (LEN)
    ) u_beat_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_fire),
        .i_clr (w_clr),
        .o_tc  (w_last)
    );

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_ACCUM;
            r_acc     <= '0;
            r_acc_out <= '0;
            r_sticky  <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (w_clr) begin
                        r_acc    <= '0;
                        r_sticky <= 1'b0;
                    end else if (w_fire) begin
                        if (w_last) begin
                            r_acc_out <= w_sum[ACC_W-1:0];
                            r_ovf     <= w_sum[ACC_W] | r_sticky;
                            r_acc     <= '0;
                            r_sticky  <= 1'b0;
                            r_state   <= ST_HOLD;
                        end else begin
                            r_acc    <= w_sum[ACC_W-1:0];
                            r_sticky <= r_sticky | w_sum[ACC_W];
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        r_ovf   <= 1'b0;
                        r_state <= ST_ACCUM;
                    end
                end
                default: r_state <= ST_ACCUM;
            endcase
        end
    end

    // Handshake outputs depend only on the state register.
    assign in_ready  = w_accum;
    assign out_valid = (r_state == ST_HOLD);
    assign acc_out   = r_acc_out;
    assign ovf       = r_ovf;

endmodule
